// File: rtl/instr_fetch.sv
// Instruction fetch sequencer for the proc datapath: reads words from a
// synchronous-read memory, issues each one with a Run strobe and waits for Done.
module instr_fetch #(
  parameter int          ADDR_W  = 8,
  parameter int          TIMEOUT = 8,
  parameter logic [2:0]  HALT_OP = 3'b111
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Go,
  input  logic              Stop,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [15:0]       DIN,
  output logic              Run,
  input  logic              Done,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       instr_count,
  output logic              Halted,
  output logic              Fault
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LATCH = 3'd2;
  localparam logic [2:0] ISSUE = 3'd3;
  localparam logic [2:0] EXEC  = 3'd4;
  localparam logic [2:0] HALT  = 3'd5;

  localparam int WD_W = $clog2(TIMEOUT) + 1;

  logic [2:0]      state;
  logic            stop_pending;
  logic [WD_W-1:0] watchdog;
  logic            parked;
  logic            start;
  logic            wd_expired;
  logic            to_idle;

  assign parked     = (state == IDLE) || (state == HALT);
  assign start      = parked && Go && !Stop;
  assign wd_expired = (watchdog == WD_W'(TIMEOUT - 1));
  assign to_idle    = ((state == FETCH) && stop_pending) ||
                      ((state == EXEC) && Done && (stop_pending || Stop));

  assign mem_addr = pc;
  assign Run      = (state == ISSUE);
  assign Halted   = (state == HALT);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= IDLE;
      pc          <= '0;
      DIN         <= '0;
      instr_count <= '0;
      Fault       <= 1'b0;
      watchdog    <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc          <= '0;
            instr_count <= '0;
            Fault       <= 1'b0;
            state       <= FETCH;
          end
        end
        FETCH: state <= stop_pending ? IDLE : LATCH;
        // A halt word is latched into DIN but never issued or retired.
        LATCH: begin
          DIN   <= mem_data;
          state <= (mem_data[15:13] == HALT_OP) ? HALT : ISSUE;
        end
        ISSUE: begin
          watchdog <= '0;
          state    <= EXEC;
        end
        EXEC: begin
          watchdog <= watchdog + 1'b1;
          if (Done) begin
            pc <= pc + 1'b1;
            if (instr_count != 16'hFFFF)
              instr_count <= instr_count + 1'b1;
            state <= (stop_pending || Stop) ? IDLE : FETCH;
          end else if (wd_expired) begin
            Fault <= 1'b1;
            state <= HALT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stop is remembered until the next instruction boundary; parked states drop it.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      stop_pending <= 1'b0;
    else if (parked || to_idle)
      stop_pending <= 1'b0;
    else if (Stop)
      stop_pending <= 1'b1;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random programs
// compared against a transaction-level model of fetch/issue/retire timing.
module tb_instr_fetch;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 8;
  localparam int MEM_N   = 1 << ADDR_W;

  logic              Clock = 1'b0;
  logic              Resetn;
  logic              Go;
  logic              Stop;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic [15:0]       DIN;
  logic              Run;
  logic              Done;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       instr_count;
  logic              Halted;
  logic              Fault;

  logic [15:0] mem [0:MEM_N-1];

  int vectors     = 0;
  int miscompares = 0;

  logic        procBusy;
  logic        procStuck;
  int          procStep;
  int          procLen;
  logic [15:0] procIr;
  logic [15:0] r0;

  instr_fetch #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .HALT_OP(3'b111)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .Go          (Go),
    .Stop        (Stop),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .DIN         (DIN),
    .Run         (Run),
    .Done        (Done),
    .pc          (pc),
    .instr_count (instr_count),
    .Halted      (Halted),
    .Fault       (Fault)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) mem_data <= mem[mem_addr];

  function automatic int execLen(input logic [15:0] w);
    return (w[15:13] <= 3'd1) ? 1 : 3;
  endfunction

  function automatic logic [15:0] applyOp(input logic [15:0] w, input logic [15:0] r);
    logic [15:0] imm;
    imm = {7'b0, w[8:0]};
    if (w[11:9] != 3'd0 || !w[12]) return r;
    case (w[15:13])
      3'd0:    return imm;
      3'd1:    return {w[7:0], 8'h00};
      3'd2:    return r + imm;
      3'd3:    return r - imm;
      default: return r;
    endcase
  endfunction

  // Minimal proc stand-in: Done is combinational in the last EXEC step.
  assign Done = procBusy && !procStuck && (procStep == procLen - 1);

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      procBusy <= 1'b0;
      procStep <= 0;
      procLen  <= 1;
      procIr   <= '0;
      r0       <= '0;
    end else if (Run) begin
      procBusy <= 1'b1;
      procStep <= 0;
      procLen  <= execLen(DIN);
      procIr   <= DIN;
    end else if (procBusy) begin
      if (Done) begin
        procBusy <= 1'b0;
        r0       <= applyOp(procIr, r0);
      end else begin
        procStep <= procStep + 1;
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Pulses Go, runs the program in mem and compares against a walk of the
  // program: each retired word costs FETCH+LATCH+ISSUE plus its EXEC length.
  task automatic applyStimulus(input int stopAt);
    logic [15:0] expWords[$];
    logic [15:0] gotWords[$];
    int          expCycles[$];
    int          gotCycles[$];
    int          pcM, cyc, retired, haltExp, haltGot, budget;
    logic [15:0] w;
    pcM = 0; cyc = 1; retired = 0; haltExp = -1;
    while (retired < 1000) begin
      w = mem[pcM];
      if (w[15:13] == 3'b111) begin
        haltExp = cyc + 2;
        break;
      end
      expWords.push_back(w);
      expCycles.push_back(cyc + 2);
      cyc += 3 + execLen(w);
      pcM = (pcM + 1) % MEM_N;
      retired++;
      if (retired - 1 == stopAt) break;
    end
    budget = ((haltExp >= 0) ? haltExp : cyc) + 10;

    Go = 1'b1;
    haltGot = -1;
    for (int c = 1; c <= budget; c++) begin
      tick();
      Go   = 1'b0;
      Stop = 1'b0;
      if (c == 1) begin
        checkOutput("startPc", pc, 0);
        checkOutput("startFault", Fault, 0);
      end
      if (Run) begin
        gotWords.push_back(DIN);
        gotCycles.push_back(c);
        if (int'(gotWords.size()) - 1 == stopAt) Stop = 1'b1;
      end
      if (Halted && haltGot < 0) haltGot = c;
    end

    checkOutput("runCount", gotWords.size(), expWords.size());
    for (int i = 0; i < expWords.size() && i < gotWords.size(); i++) begin
      checkOutput("issuedWord", gotWords[i], expWords[i]);
      checkOutput("issueCycle", gotCycles[i], expCycles[i]);
    end
    checkOutput("haltCycle", haltGot, haltExp);
    checkOutput("endPc", pc, pcM);
    checkOutput("endCount", instr_count, retired);
    checkOutput("endHalted", Halted, (haltExp >= 0) ? 1 : 0);
    checkOutput("endFault", Fault, 0);
  endtask

  task automatic loadTestProgram();
    for (int i = 0; i < MEM_N; i++) mem[i] = 16'hE000;
    mem[0] = 16'h1005;
    mem[1] = 16'h5003;
    mem[2] = 16'hE000;
  endtask

  initial begin
    int          len;
    int          stopAt;
    logic        runSeen;
    logic [15:0] w;

    Resetn = 1'b0; Go = 1'b0; Stop = 1'b0; procStuck = 1'b0;
    loadTestProgram();
    repeat (2) tick();
    Resetn = 1'b1;
    tick();
    checkOutput("rstPc", pc, 0);
    checkOutput("rstDin", DIN, 0);
    checkOutput("rstRun", Run, 0);
    checkOutput("rstCount", instr_count, 0);
    checkOutput("rstHalted", Halted, 0);
    checkOutput("rstFault", Fault, 0);

    $display("[TB] mv/add/halt program");
    applyStimulus(-1);
    checkOutput("r0AfterProg", r0, 16'd8);

    $display("[TB] Stop during first instruction");
    applyStimulus(0);
    checkOutput("r0AfterStop", r0, 16'd5);

    $display("[TB] Go and Stop together in IDLE");
    Go = 1'b1; Stop = 1'b1;
    runSeen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      Go = 1'b0; Stop = 1'b0;
      if (Run) runSeen = 1'b1;
    end
    checkOutput("goStopRun", runSeen, 0);
    checkOutput("goStopPc", pc, 1);
    checkOutput("goStopHalted", Halted, 0);
    applyStimulus(-1);

    $display("[TB] watchdog timeout");
    for (int i = 0; i < MEM_N; i++) mem[i] = 16'hE000;
    mem[0] = 16'h5003;
    procStuck = 1'b1;
    Go = 1'b1;
    for (int c = 1; c <= 4 + TIMEOUT + 2; c++) begin
      tick();
      Go = 1'b0;
      if (c == 3 + TIMEOUT) begin
        checkOutput("wdEarlyFault", Fault, 0);
        checkOutput("wdEarlyHalted", Halted, 0);
      end
      if (c == 4 + TIMEOUT) begin
        checkOutput("wdFault", Fault, 1);
        checkOutput("wdHalted", Halted, 1);
        checkOutput("wdPc", pc, 0);
        checkOutput("wdCount", instr_count, 0);
      end
    end
    procStuck = 1'b0;
    applyStimulus(-1);

    $display("[TB] async reset mid-EXEC");
    loadTestProgram();
    Go = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      Go = 1'b0;
    end
    checkOutput("preRstPc", pc, 1);
    #2 Resetn = 1'b0;
    #1;
    checkOutput("asyncPc", pc, 0);
    checkOutput("asyncAddr", mem_addr, 0);
    checkOutput("asyncDin", DIN, 0);
    checkOutput("asyncCount", instr_count, 0);
    checkOutput("asyncRun", Run, 0);
    checkOutput("asyncHalted", Halted, 0);
    tick();
    Resetn = 1'b1;
    tick();
    applyStimulus(-1);

    $display("[TB] pc wrap over the full address space");
    for (int i = 0; i < MEM_N; i++) mem[i] = 16'h1001;
    applyStimulus(257);

    $display("[TB] random programs");
    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < MEM_N; i++) mem[i] = 16'($urandom);
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        w = 16'($urandom);
        w[15:13] = 3'($urandom_range(0, 6));
        mem[i] = w;
      end
      w = 16'($urandom);
      w[15:13] = 3'b111;
      mem[len] = w;
      stopAt = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
      applyStimulus(stopAt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
